// File: rtl/cmp_share_ctrl_if.sv
// Requester/result bundle for cmp_share_ctrl: two operand-pair requesters plus the result strobe.
// The controller takes the slave modport; capture and result logic take the master modport.
interface cmp_share_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         req0_valid;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_ready;

    logic         req1_valid;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_ready;

    logic         res_valid;
    logic         res_id;
    logic         res_gt;
    logic         res_eq;
    logic         res_lt;
    logic         busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_id, res_gt, res_eq, res_lt, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_id, res_gt, res_eq, res_lt, busy
    );
endinterface

// File: rtl/cmp_share_ctrl.sv
// Round-robin shared 4-bit magnitude comparator, sequenced MSB-nibble first over 4*NIBBLES-bit operands.
// Optional build macro CMP_EARLY_EXIT_EN: stop on the first unequal nibble instead of always scanning all nibbles.
module cmp_share_ctrl #(
    parameter int NIBBLES = 4
) (
    input logic            clk,
    input logic            rst_n,
    cmp_share_ctrl_if.slave bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t             state_reg;
    logic               last_grant_reg;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic               id_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               diff_found_reg;
    logic               diff_gt_reg;
    logic               res_valid_reg;
    logic               res_id_reg;
    logic               res_gt_reg;
    logic               res_eq_reg;
    logic               res_lt_reg;

    // Arbitration: a lone requester wins; on a tie the one not granted last wins.
    logic grant0;
    logic grant1;
    logic xfer0;
    logic xfer1;

    assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_reg);
    assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_reg);

    assign bus.req0_ready = (state_reg == IDLE) & grant0;
    assign bus.req1_ready = (state_reg == IDLE) & grant1;

    assign xfer0 = bus.req0_valid & bus.req0_ready;
    assign xfer1 = bus.req1_valid & bus.req1_ready;

    logic [3:0] nib_a [NIBBLES];
    logic [3:0] nib_b [NIBBLES];

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign nib_a[gi] = a_reg[4*gi +: 4];
            assign nib_b[gi] = b_reg[4*gi +: 4];
        end
    endgenerate

    logic [3:0] cur_a;
    logic [3:0] cur_b;
    assign cur_a = nib_a[idx_reg];
    assign cur_b = nib_b[idx_reg];

    // Gate-level 4-bit magnitude compare of the current nibble pair.
    logic [3:0] bit_eq;
    logic       cmp_gt;
    logic       cmp_eq;
    logic       cmp_lt;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit_eq
            assign bit_eq[gi] = ~(cur_a[gi] ^ cur_b[gi]);
        end
    endgenerate

    assign cmp_gt = (cur_a[3] & ~cur_b[3])
                  | (bit_eq[3] & cur_a[2] & ~cur_b[2])
                  | (bit_eq[3] & bit_eq[2] & cur_a[1] & ~cur_b[1])
                  | (bit_eq[3] & bit_eq[2] & bit_eq[1] & cur_a[0] & ~cur_b[0]);
    assign cmp_lt = (~cur_a[3] & cur_b[3])
                  | (bit_eq[3] & ~cur_a[2] & cur_b[2])
                  | (bit_eq[3] & bit_eq[2] & ~cur_a[1] & cur_b[1])
                  | (bit_eq[3] & bit_eq[2] & bit_eq[1] & ~cur_a[0] & cur_b[0]);
    assign cmp_eq = &bit_eq;

    // An earlier (more significant) difference always outranks the current nibble.
    logic final_gt;
    logic final_lt;
    logic final_eq;
    logic cmp_last;

    assign final_gt = diff_found_reg ? diff_gt_reg  : cmp_gt;
    assign final_lt = diff_found_reg ? ~diff_gt_reg : cmp_lt;
    assign final_eq = ~diff_found_reg & cmp_eq;
    assign cmp_last = (EARLY_EXIT & ~cmp_eq) | (idx_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            a_reg          <= '0;
            b_reg          <= '0;
            id_reg         <= 1'b0;
            idx_reg        <= '0;
            diff_found_reg <= 1'b0;
            diff_gt_reg    <= 1'b0;
            res_valid_reg  <= 1'b0;
            res_id_reg     <= 1'b0;
            res_gt_reg     <= 1'b0;
            res_eq_reg     <= 1'b0;
            res_lt_reg     <= 1'b0;
        end else begin
            res_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (xfer0 | xfer1) begin
                        a_reg          <= xfer1 ? bus.req1_a : bus.req0_a;
                        b_reg          <= xfer1 ? bus.req1_b : bus.req0_b;
                        id_reg         <= xfer1;
                        last_grant_reg <= xfer1;
                        idx_reg        <= IDX_W'(NIBBLES - 1);
                        diff_found_reg <= 1'b0;
                        diff_gt_reg    <= 1'b0;
                        state_reg      <= CMP;
                    end
                end
                CMP: begin
                    if (cmp_last) begin
                        res_valid_reg <= 1'b1;
                        res_id_reg    <= id_reg;
                        res_gt_reg    <= final_gt;
                        res_eq_reg    <= final_eq;
                        res_lt_reg    <= final_lt;
                        state_reg     <= DONE;
                    end else begin
                        if (!diff_found_reg && !cmp_eq) begin
                            diff_found_reg <= 1'b1;
                            diff_gt_reg    <= cmp_gt;
                        end
                        idx_reg <= idx_reg - 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.res_valid = res_valid_reg;
    assign bus.res_id    = res_id_reg;
    assign bus.res_gt    = res_gt_reg;
    assign bus.res_eq    = res_eq_reg;
    assign bus.res_lt    = res_lt_reg;
    assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// Self-checking bench for cmp_share_ctrl: directed cases then randomized traffic against a
// behavioural model (integer compare, nibble scan for latency, round-robin pointer).
module tb_cmp_share_ctrl;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   last_grant = 1;

    always #5 clk = ~clk;

    cmp_share_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

    cmp_share_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency in cycles from handshake to the result strobe.
    function automatic int model_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef CMP_EARLY_EXIT_EN
        for (int k = 1; k <= NIBBLES; k++)
            if (a[W-4*k +: 4] != b[W-4*k +: 4]) return k + 1;
`endif
        return NIBBLES + 1;
    endfunction

    // Called one step after a rising edge with the DUT in IDLE; returns in the IDLE cycle after DONE.
    task automatic run_txn(input bit v0, input bit v1,
                           input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input bit hold, input string tag);
        int g;
        int lat;
        int exp_lat;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
        #1;
        if (v0 && !v1)      g = 0;
        else if (v1 && !v0) g = 1;
        else                g = (last_grant == 1) ? 0 : 1;
        last_grant = g;
        check({tag, "/ready0"}, 32'(bus.req0_ready), 32'(g == 0));
        check({tag, "/ready1"}, 32'(bus.req1_ready), 32'(g == 1));
        ea = (g == 1) ? a1 : a0;
        eb = (g == 1) ? b1 : b0;
        exp_lat = model_latency(ea, eb);
        @(posedge clk); #1;
        if (!hold) begin
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
            bus.req1_a = W'($urandom); bus.req1_b = W'($urandom);
        end
        lat = 1;
        while (!bus.res_valid && lat < 20) begin
            check({tag, "/busy_cmp"}, 32'(bus.busy), 32'd1);
            if (hold) check({tag, "/ready_cmp"}, 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/res_id"}, 32'(bus.res_id), 32'(g));
        check({tag, "/res_gt"}, 32'(bus.res_gt), 32'(ea > eb));
        check({tag, "/res_eq"}, 32'(bus.res_eq), 32'(ea == eb));
        check({tag, "/res_lt"}, 32'(bus.res_lt), 32'(ea < eb));
        check({tag, "/busy_done"}, 32'(bus.busy), 32'd1);
        check({tag, "/ready_done"}, 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        $display("[TB] txn %s id=%0d a=%h b=%h gt/eq/lt=%b%b%b lat=%0d", tag, bus.res_id, ea, eb,
                 bus.res_gt, bus.res_eq, bus.res_lt, lat);
        @(posedge clk); #1;
        check({tag, "/strobe_1cyc"}, 32'(bus.res_valid), 32'd0);
        check({tag, "/busy_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           rv0;
        bit           rv1;
        int           pos;
        int           mode;

        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst/res_valid", 32'(bus.res_valid), 32'd0);
        check("rst/res_id", 32'(bus.res_id), 32'd0);
        check("rst/res_flags", 32'({bus.res_gt, bus.res_eq, bus.res_lt}), 32'd0);
        check("rst/busy", 32'(bus.busy), 32'd0);
        check("rst/ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1, 0, 16'h1234, 16'h1234, 16'h0, 16'h0, 0, "eq_req0");
        run_txn(1, 0, 16'h0001, 16'h0002, 16'h0, 16'h0, 0, "lt_req0");
        run_txn(0, 1, 16'h0, 16'h0, 16'h8000, 16'h7FFF, 0, "gt_req1");

        // Both held valid: grants alternate starting with req0.
        for (int i = 0; i < 4; i++)
            run_txn(1, 1, 16'h4321, 16'h4300, 16'h0055, 16'h5500, 1, $sformatf("alt%0d", i));
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

        run_txn(1, 0, 16'h9100, 16'h8F00, 16'h0, 16'h0, 0, "sticky");

        // Reset in the middle of a compare.
        bus.req0_valid = 1'b1; bus.req0_a = 16'h00F0; bus.req0_b = 16'h0F00;
        #1;
        check("rstmid/ready0", 32'(bus.req0_ready), 32'(last_grant == 1 || 1'b1));
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        check("rstmid/busy_c1", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        last_grant = 1;
        #1;
        check("rstmid/busy", 32'(bus.busy), 32'd0);
        check("rstmid/res_valid", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NIBBLES + 2; i++) begin
            @(posedge clk); #1;
            check("rstmid/no_res", 32'(bus.res_valid), 32'd0);
            check("rstmid/idle", 32'(bus.busy), 32'd0);
        end
        run_txn(1, 1, 16'h0A00, 16'h0B00, 16'hFFFF, 16'h0000, 0, "rst_tie");

        for (int i = 0; i < 40; i++) begin
            rv0 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            if (!rv0 && !rv1) rv0 = 1'b1;
            ra = W'($urandom);
            rb = ra;
            mode = $urandom_range(0, 3);
            if (mode == 0) rb = W'($urandom);
            else if (mode >= 2) begin
                pos = $urandom_range(0, NIBBLES - 1);
                rb[4*pos +: 4] = 4'($urandom);
            end
            if (rv1 && ($urandom_range(0, 1) == 1))
                run_txn(rv0, rv1, W'($urandom), W'($urandom), ra, rb, 0, $sformatf("rnd%0d", i));
            else
                run_txn(rv0, rv1, ra, rb, rb, ra, 0, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
